// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: default geometry,
// a width helper and the pixel type.
package conv_pkg;

    localparam int DATA_W_DEF       = 9;
    localparam int IMAGE_WIDTH_DEF  = 28;
    localparam int IMAGE_HEIGHT_DEF = 28;
    localparam int KERNEL_WIDTH_DEF = 5;

    typedef logic signed [DATA_W_DEF-1:0] pixel_t;

    // Bits needed to index 0..value-1. Never returns less than 1, so
    // an index port is never zero-width.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/line_delay.sv
// Enable-gated row delay: LEN words deep, cleared by the asynchronous
// reset. q is the word that was shifted in LEN enabled beats ago.
module line_delay #(
    parameter int DATA_W = 9,
    parameter int LEN    = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem_r [LEN];

    // Shift one word along the delay on each enabled beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LEN; i++) begin
                mem_r[i] <= '0;
            end
        end else if (en) begin
            mem_r[0] <= d;
            for (int i = 1; i < LEN; i++) begin
                mem_r[i] <= mem_r[i-1];
            end
        end
    end

    assign q = mem_r[LEN-1];

endmodule

// File: rtl/conv_line_buffer.sv
// Line buffer for the convolution datapath. Holds KERNEL_WIDTH-1 image
// rows and presents one vertical column of taps per accepted pixel,
// together with its frame position and validity qualifiers.
// Optional build macro LINE_BUF_ZERO_PAD_EN: taps above the top image
// edge read as zero, and the column is qualified on every pixel.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
    parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
    parameter int KERNEL_WIDTH = KERNEL_WIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    input  logic                                sof,
    input  logic signed [DATA_W-1:0]            data_in,
    output logic                                out_valid,
    output logic [KERNEL_WIDTH*DATA_W-1:0]      col_out,
    output logic                                col_valid,
    output logic                                win_valid,
    output logic [clog2(IMAGE_HEIGHT)-1:0]      row_idx,
    output logic [clog2(IMAGE_WIDTH)-1:0]       col_idx,
    output logic                                eof
);

    localparam int ROW_W = clog2(IMAGE_HEIGHT);
    localparam int COL_W = clog2(IMAGE_WIDTH);

    logic [DATA_W-1:0] slice0_r;
    logic [DATA_W-1:0] tap_s [KERNEL_WIDTH];
    logic [ROW_W-1:0]  row_idx_r, nrow_r, pos_row_s, nrow_next_s;
    logic [COL_W-1:0]  col_idx_r, ncol_r, pos_col_s, ncol_next_s;
    logic              out_valid_r, col_valid_r, win_valid_r, eof_r;
    logic              row_ok_s, col_ok_s, last_s;

    // Tap 0 is the newest pixel; each further tap is one full row later.
    assign tap_s[0] = slice0_r;

    genvar k;
    generate
        for (k = 1; k < KERNEL_WIDTH; k++) begin : gen_dly
            line_delay #(
                .DATA_W (DATA_W),
                .LEN    (IMAGE_WIDTH)
            ) u_dly (
                .clk   (clk),
                .reset (reset),
                .en    (in_valid),
                .d     (tap_s[k-1]),
                .q     (tap_s[k])
            );
        end
    endgenerate

    // Position of the pixel being accepted (sof resyncs to the frame origin).
    always_comb begin
        pos_row_s = nrow_r;
        pos_col_s = ncol_r;
        if (sof) begin
            pos_row_s = '0;
            pos_col_s = '0;
        end else begin
            pos_row_s = nrow_r;
            pos_col_s = ncol_r;
        end
    end

    // Position expected for the following pixel, with row/frame wrap.
    always_comb begin
        ncol_next_s = pos_col_s + COL_W'(1);
        nrow_next_s = pos_row_s;
        if (pos_col_s == COL_W'(IMAGE_WIDTH - 1)) begin
            ncol_next_s = '0;
            if (pos_row_s == ROW_W'(IMAGE_HEIGHT - 1)) begin
                nrow_next_s = '0;
            end else begin
                nrow_next_s = pos_row_s + ROW_W'(1);
            end
        end else begin
            ncol_next_s = pos_col_s + COL_W'(1);
            nrow_next_s = pos_row_s;
        end
    end

    assign last_s   = (pos_row_s == ROW_W'(IMAGE_HEIGHT - 1)) &&
                      (pos_col_s == COL_W'(IMAGE_WIDTH - 1));
    assign col_ok_s = (int'(pos_col_s) >= KERNEL_WIDTH - 1);
`ifdef LINE_BUF_ZERO_PAD_EN
    assign row_ok_s = 1'b1;
`else
    assign row_ok_s = (int'(pos_row_s) >= KERNEL_WIDTH - 1);
`endif

    // Output qualifiers, newest tap and frame position, updated per accepted pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slice0_r    <= '0;
            row_idx_r   <= '0;
            col_idx_r   <= '0;
            nrow_r      <= '0;
            ncol_r      <= '0;
            out_valid_r <= 1'b0;
            col_valid_r <= 1'b0;
            win_valid_r <= 1'b0;
            eof_r       <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            col_valid_r <= in_valid && row_ok_s;
            win_valid_r <= in_valid && row_ok_s && col_ok_s;
            eof_r       <= in_valid && last_s;
            if (in_valid) begin
                slice0_r  <= data_in;
                row_idx_r <= pos_row_s;
                col_idx_r <= pos_col_s;
                nrow_r    <= nrow_next_s;
                ncol_r    <= ncol_next_s;
            end
        end
    end

    // Pack the taps onto col_out, blanking rows above the image top when padding.
    always_comb begin
        col_out = '0;
        for (int r = 0; r < KERNEL_WIDTH; r++) begin
`ifdef LINE_BUF_ZERO_PAD_EN
            if (r > int'(row_idx_r)) begin
                col_out[r*DATA_W +: DATA_W] = '0;
            end else begin
                col_out[r*DATA_W +: DATA_W] = tap_s[r];
            end
`else
            col_out[r*DATA_W +: DATA_W] = tap_s[r];
`endif
        end
    end

    assign out_valid = out_valid_r;
    assign col_valid = col_valid_r;
    assign win_valid = win_valid_r;
    assign eof       = eof_r;
    assign row_idx   = row_idx_r;
    assign col_idx   = col_idx_r;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Scoreboard bench for conv_line_buffer (DATA_W=9, 4x4 image, 3-tap column).
module tb_conv_line_buffer;

    localparam int DW = 9;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int KW = 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  sof = 1'b0;
    logic signed [DW-1:0]  data_in = '0;
    logic                  out_valid;
    logic [KW*DW-1:0]      col_out;
    logic                  col_valid;
    logic                  win_valid;
    logic [1:0]            row_idx;
    logic [1:0]            col_idx;
    logic                  eof;

    conv_line_buffer #(
        .DATA_W       (DW),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .KERNEL_WIDTH (KW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .sof       (sof),
        .data_in   (data_in),
        .out_valid (out_valid),
        .col_out   (col_out),
        .col_valid (col_valid),
        .win_valid (win_valid),
        .row_idx   (row_idx),
        .col_idx   (col_idx),
        .eof       (eof)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KW*DW-1:0] col;
        logic             cv;
        logic             wv;
        logic             ef;
        logic [1:0]       row;
        logic [1:0]       cx;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] hist[$];
    int            mrow = 0;
    int            mcol = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    exp_t          mon_e;
    logic [KW*DW-1:0] prev_col = '0;
    logic [1:0]    prev_row = '0;
    logic [1:0]    prev_cx = '0;
    int            first_win;
    int            vals[11] = '{-256, 255, -1, 10, 11, 12, 13, 14, 15, 16, 17};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: expected column built from the accepted-pixel history.
    task automatic send(input int d, input bit s);
        exp_t          e;
        int            r, c, n, idx;
        logic [DW-1:0] v;
        if (s) begin
            r = 0;
            c = 0;
        end else begin
            r = mrow;
            c = mcol;
        end
        hist.push_back(DW'(d));
        n = hist.size();
        e.col = '0;
        for (int k = 0; k < KW; k++) begin
            idx = n - 1 - k * IW;
            v = '0;
            if (idx >= 0) v = hist[idx];
`ifdef LINE_BUF_ZERO_PAD_EN
            if (k > r) v = '0;
`endif
            e.col[k*DW +: DW] = v;
        end
`ifdef LINE_BUF_ZERO_PAD_EN
        e.cv = 1'b1;
`else
        e.cv = (r >= KW - 1);
`endif
        e.wv  = e.cv && (c >= KW - 1);
        e.ef  = (r == IH - 1) && (c == IW - 1);
        e.row = 2'(r);
        e.cx  = 2'(c);
        sb_q.push_back(e);
        if (c == IW - 1) begin
            mcol = 0;
            mrow = (r == IH - 1) ? 0 : r + 1;
        end else begin
            mcol = c + 1;
            mrow = r;
        end
        in_valid = 1'b1;
        data_in  = DW'(d);
        sof      = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ov"},  out_valid, 0);
        chk({tag, "_col"}, col_out,   0);
        chk({tag, "_cv"},  col_valid, 0);
        chk({tag, "_wv"},  win_valid, 0);
        chk({tag, "_row"}, row_idx,   0);
        chk({tag, "_cx"},  col_idx,   0);
        chk({tag, "_eof"}, eof,       0);
    endtask

    // Monitor: pops expectations on output beats, checks hold on idle cycles.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            prev_col <= '0;
            prev_row <= '0;
            prev_cx  <= '0;
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mon_unexpected: got out_valid=1, expected no output");
            end else begin
                mon_e = sb_q.pop_front();
                chk("mon_col", col_out,   mon_e.col);
                chk("mon_cv",  col_valid, mon_e.cv);
                chk("mon_wv",  win_valid, mon_e.wv);
                chk("mon_eof", eof,       mon_e.ef);
                chk("mon_row", row_idx,   mon_e.row);
                chk("mon_cx",  col_idx,   mon_e.cx);
            end
            prev_col <= col_out;
            prev_row <= row_idx;
            prev_cx  <= col_idx;
        end else begin
            chk("hold_col", col_out,   prev_col);
            chk("hold_row", row_idx,   prev_row);
            chk("hold_cx",  col_idx,   prev_cx);
            chk("idle_cv",  col_valid, 0);
            chk("idle_wv",  win_valid, 0);
            chk("idle_eof", eof,       0);
        end
    end

    initial begin
        #21;
        chk_zero("rst");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1: pixels 1..16, continuous valid.
        first_win = 0;
        for (int i = 1; i <= 16; i++) begin
            send(i, i == 1);
`ifdef LINE_BUF_ZERO_PAD_EN
            chk($sformatf("t1_cv_p%0d", i), col_valid, 1);
`else
            chk($sformatf("t1_cv_p%0d", i), col_valid, (i >= 9));
`endif
            chk($sformatf("t1_eof_p%0d", i), eof, (i == 16));
            if (win_valid && first_win == 0) first_win = i;
            if (i == 9) chk("t1_col_p9", col_out, {9'd1, 9'd5, 9'd9});
        end
`ifdef LINE_BUF_ZERO_PAD_EN
        chk("t1_first_win", first_win, 3);
`else
        chk("t1_first_win", first_win, 11);
`endif

        // Frame 2: same stream, valid toggling every cycle.
        for (int i = 1; i <= 16; i++) begin
            send(i, i == 1);
            if (i == 1) begin
`ifdef LINE_BUF_ZERO_PAD_EN
                chk("t2_col_p1", col_out, {9'd0, 9'd0, 9'd1});
                chk("t2_cv_p1", col_valid, 1);
`else
                chk("t2_col_p1", col_out, {9'd9, 9'd13, 9'd1});
                chk("t2_cv_p1", col_valid, 0);
`endif
            end
            @(posedge clk);
            #1;
        end

        // Signed extremes pass through the row delays unchanged.
        for (int i = 0; i < 11; i++) begin
            send(vals[i], i == 0);
            if (i == 4)  chk("t3_s1_neg256", col_out[DW +: DW], 9'h100);
            if (i == 5)  chk("t3_s1_255",    col_out[DW +: DW], 9'h0FF);
            if (i == 8)  chk("t3_s2_neg256", col_out[2*DW +: DW], 9'h100);
            if (i == 10) chk("t3_s2_neg1",   col_out[2*DW +: DW], 9'h1FF);
        end

        // Mid-frame resync at pixel 7.
        for (int i = 1; i <= 6; i++) send(100 + i, i == 1);
        send(107, 1'b1);
        chk("t4_row", row_idx, 0);
        chk("t4_cx",  col_idx, 0);
        for (int j = 1; j <= 9; j++) begin
            send(107 + j, 1'b0);
            chk($sformatf("t4_eof_%0d", j), eof, 0);
`ifndef LINE_BUF_ZERO_PAD_EN
            chk($sformatf("t4_cv_%0d", j), col_valid, (j >= 8));
`endif
        end

        // Reset pulsed mid-frame after pixel 10.
        for (int i = 1; i <= 10; i++) send(30 + i, i == 1);
        @(negedge clk);
        #1;
        chk("t5_sb_drained", sb_q.size(), 0);
        reset = 1'b0;
        #1;
        chk_zero("t5_rst");
        hist.delete();
        mrow = 0;
        mcol = 0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(50, 1'b0);
        chk("t5_row", row_idx, 0);
        chk("t5_cx",  col_idx, 0);
        chk("t5_upper", col_out[KW*DW-1:DW], 0);
        send(51, 1'b0);
        send(52, 1'b0);
        chk("t5_col3", col_out, {9'd0, 9'd0, 9'd52});

        @(negedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_line_buffer.md
Name: conv_line_buffer

Overview:
- Parametrised line buffer for the convolution datapath. It generalises the fixed 9-bit row-delay shifter to any pixel width, image width and kernel height.
- Holds KERNEL_WIDTH-1 full image rows and presents one vertical column of KERNEL_WIDTH pixels per accepted input pixel, with valid qualification and frame position tracking.
- Sits between the pixel source and the kernel window/MAC array. The window array takes col_out and shifts horizontally itself.

Parameters:
- DATA_W, 9, signed pixel width in bits.
- IMAGE_WIDTH, 28, pixels per image row; length of each row delay.
- IMAGE_HEIGHT, 28, rows per frame.
- KERNEL_WIDTH, 5, kernel height = number of column taps; the buffer stores KERNEL_WIDTH-1 rows.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- in_valid  in  1  data_in is valid this cycle; the buffer shifts only when this is high.
- sof  in  1  start of frame; only sampled when in_valid=1.
- data_in  in  DATA_W  signed pixel.
- out_valid  out  1  col_out updated this cycle.
- col_out  out  KERNEL_WIDTH*DATA_W  column taps; slice r at [r*DATA_W +: DATA_W]. r=0 is the newest pixel; r=k is the same column, k rows earlier.
- col_valid  out  1  qualifies col_out: all KERNEL_WIDTH taps belong to the current frame (row >= KERNEL_WIDTH-1).
- win_valid  out  1  col_valid and col >= KERNEL_WIDTH-1; a full KxK window is available downstream.
- row_idx  out  clog2(IMAGE_HEIGHT)  row of the pixel now in slice 0.
- col_idx  out  clog2(IMAGE_WIDTH)  column of the pixel now in slice 0.
- eof  out  1  one-cycle pulse with the output of the last pixel of a frame.

Behaviour:
- Reset (reset=0, asynchronous): every output and all storage go to 0; row and column counters go to 0. Reset mid-frame discards the frame. After release, the first accepted pixel is row 0, col 0 whether or not sof is asserted.
- Latency: 1 cycle. A pixel accepted at edge t appears in slice 0 after edge t, with out_valid=1. In the same cycle, slice r holds the pixel accepted exactly r*IMAGE_WIDTH accepted beats earlier.
- Row delays: row delay k takes slice k-1's input stream and delays it by IMAGE_WIDTH accepted beats. Idle cycles never count.
- Stall (in_valid=0):
  - No shift; counters hold.
  - out_valid=0, col_valid=0, win_valid=0, eof=0.
  - col_out, row_idx and col_idx hold their last values.
- Counters advance on each accepted pixel:
  - col increments and wraps IMAGE_WIDTH-1 -> 0, incrementing row.
  - At row IMAGE_HEIGHT-1, col IMAGE_WIDTH-1, row wraps to 0 and eof=1 on that output cycle.
- sof with in_valid=1 forces the accepted pixel to row 0, col 0, overriding the counters. This applies mid-frame too (resync, no eof). sof with in_valid=0 is ignored.
- Storage is not cleared between frames. Previous-frame rows remain in the delays, and col_valid suppresses them until row >= KERNEL_WIDTH-1.
- Arithmetic: data is moved without change; there is no sign extension or truncation.
- Counters use the registered index plus 1 with wrap compare. There is no behaviour for indices outside range.

Optional Feature:
- Macro: LINE_BUF_ZERO_PAD_EN.
- Defined: slice r of col_out reads as 0 whenever r > row_idx (top-edge zero padding). col_valid is then asserted for every accepted pixel, and win_valid = col_valid and col_idx >= KERNEL_WIDTH-1.
- Undefined: stale slices pass through unchanged and col_valid follows the rule above.

Decomposition:
- Shared package (conv_pkg):
  - default DATA_W, IMAGE_WIDTH, IMAGE_HEIGHT and KERNEL_WIDTH constants.
  - a clog2 function.
  - a pixel typedef (signed [DATA_W-1:0]).
- Sub-module line_delay:
  - parameters DATA_W and LEN.
  - ports clk, reset, en, d and q: an enable-gated shift register of LEN words with reset to 0.
- The top instantiates KERNEL_WIDTH-1 line_delay instances and adds the counters and output registers.

Test Plan (DATA_W=9, IMAGE_WIDTH=4, IMAGE_HEIGHT=4, KERNEL_WIDTH=3 unless noted):
- Reset then 16 pixels 1..16, continuous valid, sof on pixel 1:
  - after pixel 9, col_out = {9 newest, 5, 1} and col_valid=1.
  - pixels 1-8 give col_valid=0.
  - win_valid first high on pixel 11.
  - eof on pixel 16 only.
- Same stream with in_valid toggling 1,0 every cycle: identical col_out sequence on out_valid cycles; outputs hold during gaps.
- Signed data -256, 255, -1 through all rows: values emerge unchanged in slices 1 and 2 after 4 and 8 beats.
- sof reasserted at pixel 7: row_idx=0, col_idx=0 on that output; col_valid=0 until 8 further pixels; no eof.
- reset pulsed low mid-frame after pixel 10: all outputs 0 immediately; the next pixel reports row 0, col 0 with slices 1 and 2 = 0.
- With LINE_BUF_ZERO_PAD_EN, second frame after a full first frame: pixel 1 gives col_out = {v, 0, 0} and col_valid=1. Without the macro, slices 1 and 2 show previous-frame data and col_valid=0.
